// File: rtl/vit_frame_sequencer.sv
// Frame sequencer for viterbi_core: streams softbit words into the input buffer, kicks the core,
// counts output bytes and repeats for a latched frame count. Optional watchdog: VIT_SEQ_TIMEOUT_EN.
module vit_frame_sequencer #(
  parameter int SRC_ADDR_W = 12,
  parameter int SB_W       = 24,
  parameter int LEN_W      = 12,
  parameter int FRM_W      = 8,
  parameter int GAP_W      = 8,
  parameter int BYTE_W     = 10,
  parameter int TO_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_sync_i,
  input  logic                  start_i,
  input  logic [FRM_W-1:0]      frame_cnt_i,
  input  logic [LEN_W-1:0]      words_i,
  input  logic [SRC_ADDR_W-1:0] src_base_i,
  input  logic [GAP_W-1:0]      gap_i,
  input  logic [TO_W-1:0]       timeout_i,
  input  logic                  in_valid_i,
  input  logic [SB_W-1:0]       in_data_i,
  output logic                  in_ready_o,
  output logic                  ibuf_wr_o,
  output logic [SRC_ADDR_W-1:0] ibuf_addr_o,
  output logic [SB_W-1:0]       ibuf_wdata_o,
  output logic                  core_frame_start_o,
  input  logic                  core_frame_done_i,
  input  logic                  dst_wr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [FRM_W-1:0]      frames_done_o,
  output logic [BYTE_W-1:0]     last_bytes_o,
  output logic                  timeout_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_KICK, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [FRM_W-1:0]      frame_cnt_q;
  logic [LEN_W-1:0]      words_q;
  logic [LEN_W-1:0]      idx;
  logic [SRC_ADDR_W-1:0] src_base_q;
  logic [GAP_W-1:0]      gap_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic [BYTE_W-1:0]     byte_next;
  logic                  hs;

`ifdef VIT_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]       timeout_q;
  logic [TO_W-1:0]       wd_cnt;
  logic                  wd_expire;

  // wd_cnt+1 is the number of WAIT cycles including the current one
  assign wd_expire = (timeout_q != '0) && ((wd_cnt + TO_W'(1)) == timeout_q);
`else
  logic                  timeout_unused;

  assign timeout_unused = ^timeout_i;
  assign timeout_o      = 1'b0;
`endif

  assign in_ready_o = (state == S_LOAD);
  assign busy_o     = (state != S_IDLE);
  assign hs         = in_valid_i & in_ready_o;

  // A byte strobe coinciding with frame_done is included in the latched count
  always_comb begin
    byte_next = byte_cnt;
    if (dst_wr_i && (byte_cnt != '1)) byte_next = byte_cnt + BYTE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state              <= S_IDLE;
      frame_cnt_q        <= '0;
      words_q            <= '0;
      idx                <= '0;
      src_base_q         <= '0;
      gap_q              <= '0;
      gap_cnt            <= '0;
      byte_cnt           <= '0;
      ibuf_wr_o          <= 1'b0;
      ibuf_addr_o        <= '0;
      ibuf_wdata_o       <= '0;
      core_frame_start_o <= 1'b0;
      done_o             <= 1'b0;
      frames_done_o      <= '0;
      last_bytes_o       <= '0;
`ifdef VIT_SEQ_TIMEOUT_EN
      timeout_q          <= '0;
      wd_cnt             <= '0;
      timeout_o          <= 1'b0;
`endif
    end else begin
      ibuf_wr_o          <= 1'b0;
      core_frame_start_o <= 1'b0;
      done_o             <= 1'b0;
      if (state != S_GAP) gap_cnt <= GAP_W'(1);

      case (state)
        S_IDLE: begin
          if (start_i) begin
            frame_cnt_q   <= frame_cnt_i;
            words_q       <= words_i;
            src_base_q    <= src_base_i;
            gap_q         <= gap_i;
            idx           <= '0;
            frames_done_o <= '0;
`ifdef VIT_SEQ_TIMEOUT_EN
            timeout_q     <= timeout_i;
            timeout_o     <= 1'b0;
`endif
            if (frame_cnt_i == '0)  state <= S_DONE;
            else if (words_i == '0) state <= S_GAP;
            else                    state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (hs) begin
            ibuf_wr_o    <= 1'b1;
            ibuf_addr_o  <= src_base_q + SRC_ADDR_W'(idx);
            ibuf_wdata_o <= in_data_i;
            idx          <= idx + LEN_W'(1);
            if (idx == (words_q - LEN_W'(1))) state <= S_GAP;
          end
        end
        S_GAP: begin
          // gap=0 and gap=1 both leave after a single cycle
          if (gap_cnt >= gap_q) begin
            core_frame_start_o <= 1'b1;
            state              <= S_KICK;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_KICK: begin
          byte_cnt <= '0;
`ifdef VIT_SEQ_TIMEOUT_EN
          wd_cnt   <= '0;
`endif
          state    <= S_WAIT;
        end
        S_WAIT: begin
          byte_cnt <= byte_next;
`ifdef VIT_SEQ_TIMEOUT_EN
          wd_cnt   <= wd_cnt + TO_W'(1);
`endif
          if (core_frame_done_i) begin
            last_bytes_o  <= byte_next;
            frames_done_o <= frames_done_o + FRM_W'(1);
            if ((frames_done_o + FRM_W'(1)) == frame_cnt_q) begin
              state <= S_DONE;
            end else begin
              idx   <= '0;
              state <= (words_q == '0) ? S_GAP : S_LOAD;
            end
          end
`ifdef VIT_SEQ_TIMEOUT_EN
          else if (wd_expire) begin
            timeout_o <= 1'b1;
            state     <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_frame_sequencer.sv
// Directed bench for vit_frame_sequencer: stream driver and core model feed a write scoreboard;
// directed steps check counters, pulses and zero/wrap/reset cases.
module tb_vit_frame_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_sync_i;
  logic        start_i;
  logic [7:0]  frame_cnt_i;
  logic [11:0] words_i;
  logic [11:0] src_base_i;
  logic [7:0]  gap_i;
  logic [15:0] timeout_i;
  logic        in_valid_i;
  logic [23:0] in_data_i;
  logic        in_ready_o;
  logic        ibuf_wr_o;
  logic [11:0] ibuf_addr_o;
  logic [23:0] ibuf_wdata_o;
  logic        core_frame_start_o;
  logic        core_frame_done_i;
  logic        dst_wr_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  frames_done_o;
  logic [9:0]  last_bytes_o;
  logic        timeout_o;

  vit_frame_sequencer #(
    .SRC_ADDR_W(12), .SB_W(24), .LEN_W(12), .FRM_W(8),
    .GAP_W(8), .BYTE_W(10), .TO_W(16)
  ) dut (
    .clk_i(clk_i), .rst_sync_i(rst_sync_i), .start_i(start_i),
    .frame_cnt_i(frame_cnt_i), .words_i(words_i), .src_base_i(src_base_i),
    .gap_i(gap_i), .timeout_i(timeout_i), .in_valid_i(in_valid_i),
    .in_data_i(in_data_i), .in_ready_o(in_ready_o), .ibuf_wr_o(ibuf_wr_o),
    .ibuf_addr_o(ibuf_addr_o), .ibuf_wdata_o(ibuf_wdata_o),
    .core_frame_start_o(core_frame_start_o), .core_frame_done_i(core_frame_done_i),
    .dst_wr_i(dst_wr_i), .busy_o(busy_o), .done_o(done_o),
    .frames_done_o(frames_done_o), .last_bytes_o(last_bytes_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_starts = 0;
  int  n_dones = 0;
  int  n_writes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream source: decides valid just after each edge, so ready reflects the state of the next edge
  logic        stream_en = 1'b0;
  logic        bubble = 1'b0;
  logic        phase = 1'b1;
  int unsigned s_idx = 0;
  int unsigned s_words = 1;
  logic [11:0] s_base = '0;
  logic [23:0] s_data = 24'h0A0001;

  always @(posedge clk_i) begin
    #1;
    if (stream_en) begin
      in_valid_i = bubble ? phase : 1'b1;
      phase      = ~phase;
      in_data_i  = s_data;
      if (in_valid_i && in_ready_o && s_words != 0) begin
        sb_q.push_back({s_base + 12'(s_idx % s_words), s_data});
        s_idx++;
        s_data = s_data + 24'h013579;
      end
    end else begin
      in_valid_i = 1'b0;
    end
  end

  // Core model: after frame_start, c_bytes strobes then frame_done on WAIT cycle c_lat
  int unsigned c_lat = 10;
  int unsigned c_bytes = 1;
  int unsigned c_cnt = 0;
  logic        c_active = 1'b0;
  logic        c_never = 1'b0;

  always @(posedge clk_i) begin
    #1;
    dst_wr_i          = 1'b0;
    core_frame_done_i = 1'b0;
    if (rst_sync_i) c_active = 1'b0;
    if (c_active) begin
      c_cnt++;
      dst_wr_i = (c_cnt <= c_bytes);
      if (!c_never && c_cnt == c_lat) begin
        core_frame_done_i = 1'b1;
        c_active          = 1'b0;
      end
    end
    if (core_frame_start_o) begin
      c_active = 1'b1;
      c_cnt    = 0;
    end
  end

  always @(negedge clk_i) begin
    wr_t e;
    if (ibuf_wr_o) begin
      n_writes++;
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed addr 0x%0h with empty scoreboard", ibuf_addr_o);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(ibuf_addr_o), 32'(e.addr));
        check("wr_data", 32'(ibuf_wdata_o), 32'(e.data));
      end
    end
    if (core_frame_start_o) n_starts++;
    if (done_o) begin
      n_dones++;
      check("busy_low_at_done", 32'(busy_o), 32'(0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic launch(input int fc, input int w, input int base, input int gap,
                        input int to, input int lat, input int bytes, input bit bub);
    n_starts = 0; n_dones = 0; n_writes = 0;
    s_idx = 0; s_words = (w == 0) ? 1 : w; s_base = 12'(base);
    bubble = bub; phase = 1'b1;
    c_lat = lat; c_bytes = bytes;
    frame_cnt_i = 8'(fc); words_i = 12'(w); src_base_i = 12'(base);
    gap_i = 8'(gap); timeout_i = 16'(to);
    stream_en = 1'b1;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    tick(1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (n_starts >= n) seen = 1'b1;
    end
    check("frame_start_seen", 32'(seen), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_sync_i = 1'b1; start_i = 1'b0; frame_cnt_i = '0; words_i = '0;
    src_base_i = '0; gap_i = '0; timeout_i = '0; in_valid_i = 1'b0; in_data_i = '0;
    dst_wr_i = 1'b0; core_frame_done_i = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_ready", 32'(in_ready_o), 32'(0));
    check("rst_frames", 32'(frames_done_o), 32'(0));
    check("rst_done", 32'(done_o), 32'(0));
    rst_sync_i = 1'b0;
    tick(2);

    // Basic: 3 frames of 0x152 words, 43 bytes per frame
    launch(3, 'h152, 0, 4, 0, 500, 43, 1'b0);
    wait_done("basic", 4000);
    check("basic_frames", 32'(frames_done_o), 32'(3));
    check("basic_last_bytes", 32'(last_bytes_o), 32'(43));
    check("basic_starts", 32'(n_starts), 32'(3));
    check("basic_writes", 32'(n_writes), 32'(3 * 'h152));
    check("basic_dones", 32'(n_dones), 32'(1));
    check("basic_sb_empty", 32'(sb_q.size()), 32'(0));
    check("basic_timeout", 32'(timeout_o), 32'(0));

    // Bubbles on the stream
    launch(1, 8, 'h10, 0, 0, 10, 3, 1'b1);
    wait_done("bubble", 200);
    check("bubble_writes", 32'(n_writes), 32'(8));
    check("bubble_last_bytes", 32'(last_bytes_o), 32'(3));
    check("bubble_sb_empty", 32'(sb_q.size()), 32'(0));

    // Address wrap
    launch(1, 'h20, 'hFF0, 1, 0, 8, 2, 1'b0);
    wait_done("wrap", 300);
    check("wrap_writes", 32'(n_writes), 32'('h20));
    check("wrap_sb_empty", 32'(sb_q.size()), 32'(0));

    // frame_cnt=0: done two cycles after start, no frame_start
    stream_en = 1'b0;
    n_starts = 0; n_dones = 0;
    frame_cnt_i = '0; words_i = 12'd5; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check("fc0_done_early", 32'(done_o), 32'(0));
    check("fc0_busy", 32'(busy_o), 32'(1));
    tick(1);
    check("fc0_done", 32'(done_o), 32'(1));
    tick(1);
    check("fc0_starts", 32'(n_starts), 32'(0));
    check("fc0_frames", 32'(frames_done_o), 32'(0));

    // words=0, two frames
    launch(2, 0, 0, 2, 0, 6, 2, 1'b0);
    wait_done("w0", 200);
    check("w0_starts", 32'(n_starts), 32'(2));
    check("w0_writes", 32'(n_writes), 32'(0));
    check("w0_frames", 32'(frames_done_o), 32'(2));

    // start_i during WAIT is ignored
    launch(2, 4, 'h100, 0, 0, 30, 4, 1'b0);
    wait_starts(1, 100);
    tick(3);
    frame_cnt_i = 8'd7; start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    wait_done("ign", 300);
    check("ign_frames", 32'(frames_done_o), 32'(2));
    check("ign_starts", 32'(n_starts), 32'(2));
    check("ign_dones", 32'(n_dones), 32'(1));

    // dst_wr coincident with frame_done is counted
    launch(1, 2, 0, 0, 0, 6, 6, 1'b0);
    wait_done("coinc", 100);
    check("coinc_last_bytes", 32'(last_bytes_o), 32'(6));

    // Reset in the middle of LOAD
    launch(1, 50, 'h200, 0, 0, 10, 1, 1'b0);
    tick(10);
    stream_en = 1'b0;
    tick(3);
    check("rst_sb_flushed", 32'(sb_q.size()), 32'(0));
    rst_sync_i = 1'b1;
    tick(1);
    check("mid_rst_wr", 32'(ibuf_wr_o), 32'(0));
    check("mid_rst_ready", 32'(in_ready_o), 32'(0));
    check("mid_rst_busy", 32'(busy_o), 32'(0));
    check("mid_rst_last_bytes", 32'(last_bytes_o), 32'(0));
    check("mid_rst_addr", 32'(ibuf_addr_o), 32'(0));
    rst_sync_i = 1'b0;
    tick(5);
    check("mid_rst_no_done", 32'(n_dones), 32'(0));

`ifdef VIT_SEQ_TIMEOUT_EN
    // Watchdog: never-done core, expiry on the 100th WAIT cycle
    begin
      int k = 0;
      bit seen = 1'b0;
      c_never = 1'b1;
      launch(1, 2, 0, 0, 100, 1000, 0, 1'b0);
      wait_starts(1, 50);
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk_i);
        k++;
        if (done_o) seen = 1'b1;
      end
      check("to_done_seen", 32'(seen), 32'(1));
      check("to_latency", 32'(k), 32'(102));
      check("to_flag", 32'(timeout_o), 32'(1));
      check("to_frames", 32'(frames_done_o), 32'(0));
      c_never = 1'b0;
      tick(2);
    end
    launch(1, 2, 0, 0, 100, 100, 5, 1'b0);
    wait_done("to_race", 300);
    check("to_race_flag", 32'(timeout_o), 32'(0));
    check("to_race_frames", 32'(frames_done_o), 32'(1));
    check("to_race_bytes", 32'(last_bytes_o), 32'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vit_frame_sequencer.md
Name: vit_frame_sequencer

Overview:
- Synthesizable frame sequencer for viterbi_core.
- Accepts softbit words on a valid/ready stream and writes them into the input SRAM (sram_24x4096 write port).
- Pulses frame_start, waits for frame_done, counts decoded output bytes, then repeats for a programmed number of frames.
- Replaces fixed-length, fixed-count bench-driven loading with a parametrised, config-latched engine usable on-chip or in benches.

Parameters:
SRC_ADDR_W, 12, input buffer address width
SB_W, 24, softbit word width (input buffer data width)
LEN_W, 12, width of words-per-frame count
FRM_W, 8, width of frame count
GAP_W, 8, width of inter-phase gap counter
BYTE_W, 10, width of per-frame output byte counter
TO_W, 16, watchdog counter width (used only with VIT_SEQ_TIMEOUT_EN)

Ports:
clk_i  in  1  clock; all logic rising-edge
rst_sync_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle start request; ignored while busy_o=1
frame_cnt_i  in  FRM_W  number of frames to run; latched on accepted start
words_i  in  LEN_W  softbit words per frame; latched
src_base_i  in  SRC_ADDR_W  input buffer base address; latched
gap_i  in  GAP_W  idle cycles between load end and frame_start; latched
timeout_i  in  TO_W  watchdog limit in cycles, 0 = disabled; latched
in_valid_i  in  1  stream word valid
in_data_i  in  SB_W  stream softbit word
in_ready_o  out  1  stream ready; 1 only in LOAD
ibuf_wr_o  out  1  input buffer write enable
ibuf_addr_o  out  SRC_ADDR_W  input buffer write address
ibuf_wdata_o  out  SB_W  input buffer write data
core_frame_start_o  out  1  one-cycle frame start to viterbi_core
core_frame_done_i  in  1  frame done pulse from viterbi_core
dst_wr_i  in  1  viterbi_core output byte write strobe (monitored)
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse at end of sequence
frames_done_o  out  FRM_W  frames completed in current/last sequence
last_bytes_o  out  BYTE_W  dst_wr_i count of last completed frame
timeout_o  out  1  sticky watchdog flag; cleared on accepted start

Behaviour:
- Reset: state IDLE; all outputs 0, including counters and flags. Reset mid-operation aborts within one cycle without a done_o pulse. A frame already started in the core is not cancelled.
- Start acceptance: start_i=1 in IDLE latches all config and clears frames_done_o, timeout_o, and the word index. Next state:
  - DONE if frame_cnt_i=0
  - GAP if words_i=0
  - LOAD otherwise
- LOAD:
  - in_ready_o=1 (combinational from state).
  - Each handshake (in_valid_i & in_ready_o) registers ibuf_wr_o=1, ibuf_addr_o=src_base+idx (mod 2^SRC_ADDR_W, wraps silently), and ibuf_wdata_o=in_data_i. Latency is 1 cycle, so back-to-back words are written back-to-back.
  - idx increments per handshake. When idx reaches words-1, go to GAP; in_ready_o drops in the next cycle.
  - ibuf_wr_o is 0 in every cycle with no handshake.
- GAP: count gap cycles; gap=0 gives exactly one cycle in GAP. Then go to KICK.
- KICK: core_frame_start_o=1 for exactly one cycle; clear the byte counter; go to WAIT.
- WAIT:
  - Count dst_wr_i pulses (saturating at all-ones).
  - On core_frame_done_i: latch the byte count into last_bytes_o and increment frames_done_o.
  - If frames_done+1 = frame_cnt, go to DONE; else reset idx and go to LOAD (GAP if words=0).
  - dst_wr_i and core_frame_done_i in the same cycle: that byte is included in last_bytes_o.
- DONE: done_o=1 for one cycle, then IDLE.
- Ignored inputs:
  - core_frame_done_i outside WAIT.
  - in_valid_i outside LOAD.
  - start_i outside IDLE, including the DONE cycle.
- busy_o=1 in every state except IDLE; it goes low in the same cycle done_o is high.

Optional Feature:
- Macro: VIT_SEQ_TIMEOUT_EN.
- Defined: a watchdog counter runs in WAIT (reset in KICK), active when timeout_i≠0. When the count equals timeout_i with no frame done:
  - timeout_o is set (sticky).
  - The sequencer goes to DONE (done_o pulse), and frames_done_o keeps its value.
  - frame_done in the same cycle as expiry wins: the frame is counted, no timeout is flagged.
- Undefined: no counter; timeout_o tied 0; timeout_i unused; WAIT lasts indefinitely.

Test Plan:
- Basic, 3 frames: words=0x152, frame_cnt=3, base=0, gap=4, stream always valid, core model returns done after 500 cycles with 43 dst_wr pulses. Expected: 3×338 writes at addresses 0..0x151, exactly 3 frame_start pulses, frames_done_o=3, last_bytes_o=43, one done_o.
- Backpressure/bubbles: in_valid toggles 1,0,1,0. Expected: ibuf_wr_o only on handshakes, addresses contiguous, data matches stream order.
- Address wrap: base=0xFF0, words=0x20. Expected: addresses run 0xFF0..0xFFF, then 0x000..0x00F.
- Zero cases:
  - frame_cnt=0: done_o 2 cycles after start, no frame_start.
  - words=0, frame_cnt=2: two frame_starts, no writes.
- Start/reset robustness: start_i asserted during WAIT is ignored (frame count unchanged). rst_sync_i mid-LOAD: all outputs 0 next cycle, no done_o.
- With VIT_SEQ_TIMEOUT_EN:
  - timeout=100, core never done: timeout_o=1 and done_o 100 cycles after KICK, frames_done_o=0.
  - Done exactly at cycle 100: no timeout, frame counted.
